hazard_stall_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage core; sits beside the EXE-stage forwarding unit and the pipeline registers.
- Decides per cycle whether IF/ID freeze, whether a bubble enters ID/EXE or MEM/WB, and whether IF/ID is flushed.
- Covers three cases: load-use RAW hazards (and all RAW hazards when forwarding is disabled), taken branches resolved in EXE, and multi-cycle data-memory accesses with a timeout watchdog.

---
 rtl/hazard_stall_ctrl_pkg.sv | 16 +
 rtl/hazard_detect.sv | 31 +++
 rtl/hazard_stall_ctrl.sv | 158 +++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller and its hazard detector.
`ifndef REG_FILE_ADDR_LEN
`define REG_FILE_ADDR_LEN 5
`endif

package hazard_stall_ctrl_pkg;
  localparam int REG_ADDR_W      = `REG_FILE_ADDR_LEN;
  localparam int HZ_STATE_W      = 2;
  localparam int MEM_TIMEOUT_DEF = 16;

  typedef enum logic [HZ_STATE_W-1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } hz_state_t;
endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW hazard detector: load-use, and every RAW dependency when forwarding is off.
module hazard_detect
  import hazard_stall_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src1_ID,
  input  logic [REG_ADDR_W-1:0] src2_ID,
  input  logic                  src1_vld_ID,
  input  logic                  src2_vld_ID,
  input  logic [REG_ADDR_W-1:0] dest_EXE,
  input  logic [REG_ADDR_W-1:0] dest_MEM,
  input  logic                  WB_EN_EXE,
  input  logic                  WB_EN_MEM,
  input  logic                  MEM_R_EN_EXE,
  input  logic                  fwd_en,
  output logic                  lu,
  output logic                  raw_nf,
  output logic                  hz
);
  logic match_exe;
  logic match_mem;

  // r0 is an ordinary register in this core, so it is not masked out of the compares.
  assign match_exe = (src1_vld_ID && (src1_ID == dest_EXE)) ||
                     (src2_vld_ID && (src2_ID == dest_EXE));
  assign match_mem = (src1_vld_ID && (src1_ID == dest_MEM)) ||
                     (src2_vld_ID && (src2_ID == dest_MEM));

  assign lu     = MEM_R_EN_EXE && match_exe;
  assign raw_nf = !fwd_en && ((WB_EN_EXE && match_exe) || (WB_EN_MEM && match_mem));
  assign hz     = lu || raw_nf;
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline freeze/bubble/flush sequencing with memory-wait watchdog.
// Optional perf counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] src1_ID,
  input  logic [REG_ADDR_W-1:0] src2_ID,
  input  logic                  src1_vld_ID,
  input  logic                  src2_vld_ID,
  input  logic [REG_ADDR_W-1:0] dest_EXE,
  input  logic [REG_ADDR_W-1:0] dest_MEM,
  input  logic                  WB_EN_EXE,
  input  logic                  WB_EN_MEM,
  input  logic                  MEM_R_EN_EXE,
  input  logic                  fwd_en,
  input  logic                  branch_taken_EXE,
  input  logic                  mem_access_MEM,
  input  logic                  mem_ready,
  output logic                  freeze_IF,
  output logic                  freeze_ID,
  output logic                  freeze_EXE_MEM,
  output logic                  bubble_ID_EXE,
  output logic                  bubble_MEM_WB,
  output logic                  flush_IF_ID,
  output logic                  mem_timeout,
  output logic [HZ_STATE_W-1:0] state_o,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      memwait_cnt
);
  localparam int WCNT_W = $clog2(MEM_TIMEOUT) + 1;

  hz_state_t         state;
  logic [WCNT_W-1:0] wait_cnt;
  logic              lu, raw_nf, hz;
  logic              memhold;
  logic              stall_hz;
  logic              unused_sig;

  hazard_detect u_hazard_detect (
    .src1_ID      (src1_ID),
    .src2_ID      (src2_ID),
    .src1_vld_ID  (src1_vld_ID),
    .src2_vld_ID  (src2_vld_ID),
    .dest_EXE     (dest_EXE),
    .dest_MEM     (dest_MEM),
    .WB_EN_EXE    (WB_EN_EXE),
    .WB_EN_MEM    (WB_EN_MEM),
    .MEM_R_EN_EXE (MEM_R_EN_EXE),
    .fwd_en       (fwd_en),
    .lu           (lu),
    .raw_nf       (raw_nf),
    .hz           (hz)
  );

  assign unused_sig = lu ^ raw_nf ^ stall_hz;
  assign state_o    = state;

  // Outputs are gated by rst_n so they drop asynchronously while reset is held.
  always_comb begin
    freeze_IF      = 1'b0;
    freeze_ID      = 1'b0;
    freeze_EXE_MEM = 1'b0;
    bubble_ID_EXE  = 1'b0;
    bubble_MEM_WB  = 1'b0;
    flush_IF_ID    = 1'b0;
    mem_timeout    = 1'b0;
    memhold        = 1'b0;
    stall_hz       = 1'b0;
    if (rst_n) begin
      case (state)
        RUN, MEM_WAIT: begin
          memhold = mem_access_MEM && !mem_ready;
          if (memhold) begin
            freeze_IF      = 1'b1;
            freeze_ID      = 1'b1;
            freeze_EXE_MEM = 1'b1;
            bubble_MEM_WB  = 1'b1;
          end else if (branch_taken_EXE) begin
            flush_IF_ID   = 1'b1;
            bubble_ID_EXE = 1'b1;
          end else if (hz) begin
            freeze_IF     = 1'b1;
            freeze_ID     = 1'b1;
            bubble_ID_EXE = 1'b1;
            stall_hz      = 1'b1;
          end
        end
        TIMEOUT: begin
          mem_timeout   = 1'b1;
          bubble_MEM_WB = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // wait_cnt counts frozen cycles of the current access, including the entry cycle in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (memhold) begin
            state    <= MEM_WAIT;
            wait_cnt <= WCNT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (!memhold) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WCNT_W'(MEM_TIMEOUT - 1)) begin
            state    <= TIMEOUT;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q, memwait_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q   <= '0;
      flush_q   <= '0;
      memwait_q <= '0;
    end else begin
      if (stall_hz)       stall_q   <= stall_q + 1'b1;
      if (flush_IF_ID)    flush_q   <= flush_q + 1'b1;
      if (freeze_EXE_MEM) memwait_q <= memwait_q + 1'b1;
    end
  end

  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;
  assign memwait_cnt = memwait_q;
`else
  assign stall_cnt   = '0;
  assign flush_cnt   = '0;
  assign memwait_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: reset, load-use, no-forward RAW, branch, memory wait, timeout.
module tb_hazard_stall_ctrl;
  import hazard_stall_ctrl_pkg::*;

  localparam int CNT_W = 32;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {freeze_IF, freeze_ID, freeze_EXE_MEM, bubble_ID_EXE, bubble_MEM_WB, flush_IF_ID, mem_timeout}
  localparam logic [6:0] O_NONE   = 7'b0000000;
  localparam logic [6:0] O_STALL  = 7'b1101000;
  localparam logic [6:0] O_BRANCH = 7'b0001010;
  localparam logic [6:0] O_MEM    = 7'b1110100;
  localparam logic [6:0] O_TMO    = 7'b0000101;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [REG_ADDR_W-1:0] src1_ID, src2_ID, dest_EXE, dest_MEM;
  logic                  src1_vld_ID, src2_vld_ID, WB_EN_EXE, WB_EN_MEM, MEM_R_EN_EXE;
  logic                  fwd_en, branch_taken_EXE, mem_access_MEM, mem_ready;
  logic                  freeze_IF, freeze_ID, freeze_EXE_MEM, bubble_ID_EXE, bubble_MEM_WB;
  logic                  flush_IF_ID, mem_timeout;
  logic [1:0]            state_o;
  logic [CNT_W-1:0]      stall_cnt, flush_cnt, memwait_cnt;
  logic [6:0]            outs;

  int errors = 0;
  int checks = 0;
  int exp_stall = 0, exp_flush = 0, exp_memwait = 0;
  logic [CNT_W-1:0] e_cnt;

  assign outs = {freeze_IF, freeze_ID, freeze_EXE_MEM, bubble_ID_EXE, bubble_MEM_WB,
                 flush_IF_ID, mem_timeout};

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .src1_ID          (src1_ID),
    .src2_ID          (src2_ID),
    .src1_vld_ID      (src1_vld_ID),
    .src2_vld_ID      (src2_vld_ID),
    .dest_EXE         (dest_EXE),
    .dest_MEM         (dest_MEM),
    .WB_EN_EXE        (WB_EN_EXE),
    .WB_EN_MEM        (WB_EN_MEM),
    .MEM_R_EN_EXE     (MEM_R_EN_EXE),
    .fwd_en           (fwd_en),
    .branch_taken_EXE (branch_taken_EXE),
    .mem_access_MEM   (mem_access_MEM),
    .mem_ready        (mem_ready),
    .freeze_IF        (freeze_IF),
    .freeze_ID        (freeze_ID),
    .freeze_EXE_MEM   (freeze_EXE_MEM),
    .bubble_ID_EXE    (bubble_ID_EXE),
    .bubble_MEM_WB    (bubble_MEM_WB),
    .flush_IF_ID      (flush_IF_ID),
    .mem_timeout      (mem_timeout),
    .state_o          (state_o),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt),
    .memwait_cnt      (memwait_cnt)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    src1_ID = '0; src2_ID = '0; dest_EXE = '0; dest_MEM = '0;
    src1_vld_ID = 1'b0; src2_vld_ID = 1'b0;
    WB_EN_EXE = 1'b0; WB_EN_MEM = 1'b0; MEM_R_EN_EXE = 1'b0;
    fwd_en = 1'b1; branch_taken_EXE = 1'b0;
    mem_access_MEM = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    MEM_R_EN_EXE = 1'b1; dest_EXE = 5'd3; src1_ID = 5'd3; src1_vld_ID = 1'b1;
    branch_taken_EXE = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== O_NONE) begin
      errors++; $display("FAIL reset_outs: got %b want %b", outs, O_NONE);
    end
    checks++;
    if (state_o !== 2'd0) begin
      errors++; $display("FAIL reset_state: got %0d want 0", state_o);
    end
    checks++;
    if ({stall_cnt, flush_cnt, memwait_cnt} !== '0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", stall_cnt, flush_cnt, memwait_cnt);
    end
    next_cycle();
    clear_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== O_NONE || state_o !== 2'd0) begin
      errors++; $display("FAIL reset_release: got outs=%b state=%0d want %b/0", outs, state_o, O_NONE);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    clear_inputs();
    MEM_R_EN_EXE = 1'b1; WB_EN_EXE = 1'b1; dest_EXE = 5'd3; src1_ID = 5'd3; src1_vld_ID = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== O_STALL) begin
      errors++; $display("FAIL lu_stall: got %b want %b", outs, O_STALL);
    end
    next_cycle(); exp_stall++;
    MEM_R_EN_EXE = 1'b0; WB_EN_EXE = 1'b0; dest_EXE = 5'd0;
    WB_EN_MEM = 1'b1; dest_MEM = 5'd3;
    @(negedge clk);
    checks++;
    if (outs !== O_NONE) begin
      errors++; $display("FAIL lu_release: got %b want %b", outs, O_NONE);
    end
    e_cnt = PERF ? CNT_W'(exp_stall) : '0;
    checks++;
    if (stall_cnt !== e_cnt) begin
      errors++; $display("FAIL lu_stall_cnt: got %0d want %0d", stall_cnt, e_cnt);
    end
    next_cycle();
    clear_inputs();
    MEM_R_EN_EXE = 1'b1; dest_EXE = 5'd0; src2_ID = 5'd0; src2_vld_ID = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== O_STALL) begin
      errors++; $display("FAIL lu_r0: got %b want %b", outs, O_STALL);
    end
    next_cycle(); exp_stall++;
    clear_inputs();
    MEM_R_EN_EXE = 1'b1; dest_EXE = 5'd7; src1_ID = 5'd7; src1_vld_ID = 1'b0;
    src2_ID = 5'd2; src2_vld_ID = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== O_NONE) begin
      errors++; $display("FAIL lu_invalid_src: got %b want %b", outs, O_NONE);
    end
    next_cycle();
    clear_inputs();
    WB_EN_EXE = 1'b1; dest_EXE = 5'd4; src1_ID = 5'd4; src1_vld_ID = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== O_NONE) begin
      errors++; $display("FAIL alu_fwd_no_stall: got %b want %b", outs, O_NONE);
    end
    next_cycle();
  endtask

  task automatic test_no_fwd();
    clear_inputs();
    fwd_en = 1'b0; WB_EN_EXE = 1'b1; dest_EXE = 5'd5; src1_ID = 5'd5; src1_vld_ID = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== O_STALL) begin
      errors++; $display("FAIL nf_exe: got %b want %b", outs, O_STALL);
    end
    next_cycle(); exp_stall++;
    WB_EN_EXE = 1'b0; dest_EXE = 5'd0; WB_EN_MEM = 1'b1; dest_MEM = 5'd5;
    @(negedge clk);
    checks++;
    if (outs !== O_STALL) begin
      errors++; $display("FAIL nf_mem: got %b want %b", outs, O_STALL);
    end
    next_cycle(); exp_stall++;
    WB_EN_MEM = 1'b0; dest_MEM = 5'd0;
    @(negedge clk);
    checks++;
    if (outs !== O_NONE) begin
      errors++; $display("FAIL nf_release: got %b want %b", outs, O_NONE);
    end
    e_cnt = PERF ? CNT_W'(exp_stall) : '0;
    checks++;
    if (stall_cnt !== e_cnt) begin
      errors++; $display("FAIL nf_stall_cnt: got %0d want %0d", stall_cnt, e_cnt);
    end
    next_cycle();
  endtask

  task automatic test_branch();
    clear_inputs();
    branch_taken_EXE = 1'b1;
    MEM_R_EN_EXE = 1'b1; dest_EXE = 5'd3; src1_ID = 5'd3; src1_vld_ID = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== O_BRANCH) begin
      errors++; $display("FAIL branch_over_lu: got %b want %b", outs, O_BRANCH);
    end
    next_cycle(); exp_flush++;
    clear_inputs();
    @(negedge clk);
    e_cnt = PERF ? CNT_W'(exp_flush) : '0;
    checks++;
    if (flush_cnt !== e_cnt) begin
      errors++; $display("FAIL branch_flush_cnt: got %0d want %0d", flush_cnt, e_cnt);
    end
    e_cnt = PERF ? CNT_W'(exp_stall) : '0;
    checks++;
    if (stall_cnt !== e_cnt) begin
      errors++; $display("FAIL branch_stall_cnt: got %0d want %0d", stall_cnt, e_cnt);
    end
    next_cycle();
  endtask

  task automatic test_memwait();
    clear_inputs();
    mem_access_MEM = 1'b1; mem_ready = 1'b0; branch_taken_EXE = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== O_MEM || state_o !== 2'd0) begin
      errors++; $display("FAIL mw_entry: got outs=%b state=%0d want %b/0", outs, state_o, O_MEM);
    end
    next_cycle(); exp_memwait++;
    branch_taken_EXE = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== O_MEM || state_o !== 2'd1) begin
        errors++; $display("FAIL mw_hold%0d: got outs=%b state=%0d want %b/1", i, outs, state_o, O_MEM);
      end
      next_cycle(); exp_memwait++;
    end
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== O_NONE || state_o !== 2'd1) begin
      errors++; $display("FAIL mw_release: got outs=%b state=%0d want %b/1", outs, state_o, O_NONE);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (state_o !== 2'd0) begin
      errors++; $display("FAIL mw_back_to_run: got %0d want 0", state_o);
    end
    e_cnt = PERF ? CNT_W'(exp_memwait) : '0;
    checks++;
    if (memwait_cnt !== e_cnt) begin
      errors++; $display("FAIL mw_memwait_cnt: got %0d want %0d", memwait_cnt, e_cnt);
    end
    next_cycle();
    mem_access_MEM = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== O_NONE) begin
      errors++; $display("FAIL zero_wait_outs: got %b want %b", outs, O_NONE);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (state_o !== 2'd0) begin
      errors++; $display("FAIL zero_wait_state: got %0d want 0", state_o);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_timeout();
    clear_inputs();
    mem_access_MEM = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== O_MEM) begin
        errors++; $display("FAIL tmo_freeze%0d: got %b want %b", i, outs, O_MEM);
      end
      checks++;
      if (state_o !== ((i == 0) ? 2'd0 : 2'd1)) begin
        errors++; $display("FAIL tmo_state%0d: got %0d want %0d", i, state_o, (i == 0) ? 0 : 1);
      end
      next_cycle(); exp_memwait++;
    end
    @(negedge clk);
    checks++;
    if (outs !== O_TMO || state_o !== 2'd2) begin
      errors++; $display("FAIL tmo_pulse: got outs=%b state=%0d want %b/2", outs, state_o, O_TMO);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (outs !== O_MEM || state_o !== 2'd0) begin
      errors++; $display("FAIL tmo_new_access: got outs=%b state=%0d want %b/0", outs, state_o, O_MEM);
    end
    next_cycle(); exp_memwait++;
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== O_NONE || state_o !== 2'd1) begin
      errors++; $display("FAIL tmo_new_release: got outs=%b state=%0d want %b/1", outs, state_o, O_NONE);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    e_cnt = PERF ? CNT_W'(exp_memwait) : '0;
    checks++;
    if (memwait_cnt !== e_cnt || state_o !== 2'd0) begin
      errors++; $display("FAIL tmo_end: got cnt=%0d state=%0d want %0d/0", memwait_cnt, state_o, e_cnt);
    end
    next_cycle();
  endtask

  task automatic test_reset_midwait();
    clear_inputs();
    mem_access_MEM = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) next_cycle();
    checks++;
    if (state_o !== 2'd1 || outs !== O_MEM) begin
      errors++; $display("FAIL rst_pre_wait: got outs=%b state=%0d want %b/1", outs, state_o, O_MEM);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== O_NONE || state_o !== 2'd0) begin
      errors++; $display("FAIL rst_async: got outs=%b state=%0d want %b/0", outs, state_o, O_NONE);
    end
    checks++;
    if ({stall_cnt, flush_cnt, memwait_cnt} !== '0) begin
      errors++; $display("FAIL rst_async_cnt: got %0d/%0d/%0d want 0/0/0", stall_cnt, flush_cnt, memwait_cnt);
    end
    next_cycle();
    clear_inputs();
    rst_n = 1'b1;
    exp_stall = 0; exp_flush = 0; exp_memwait = 0;
    @(negedge clk);
    checks++;
    if (outs !== O_NONE || state_o !== 2'd0 || {stall_cnt, flush_cnt, memwait_cnt} !== '0) begin
      errors++; $display("FAIL rst_after: got outs=%b state=%0d cnt=%0d/%0d/%0d want all 0",
                         outs, state_o, stall_cnt, flush_cnt, memwait_cnt);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_fwd();
    test_branch();
    test_memwait();
    test_timeout();
    test_reset_midwait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
